// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Plain-vector aliases so the state register can stay a simple logic vector
  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_CALC = S_CALC;
  localparam logic [1:0] ST_DONE = S_DONE;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor,
// keep the difference only if it did not borrow.
module div_step #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH:0]   p_shift;
  logic [WIDTH+1:0] trial;

  assign p_shift = {p_in[WIDTH-1:0], dividend_msb};

  // Subtract on the full shifted value; p_in's top bit is always 0 because the
  // remainder stays below b, so the borrow lands in trial's MSB.
  assign trial = {p_in, dividend_msb} - {2'b00, b};
  assign q_bit = ~trial[WIDTH+1];
  assign p_out = q_bit ? trial[WIDTH:0] : p_shift;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with
// valid/ready request and response ports.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH:0]   p_q,     p_d;
  logic [WIDTH-1:0] dvd_q,   dvd_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH:0]   step_p;
  logic             step_q_bit;
  logic [WIDTH-1:0] dvd_shl;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_in         (p_q),
    .dividend_msb (dvd_q[WIDTH-1]),
    .b            (b_q),
    .p_out        (step_p),
    .q_bit        (step_q_bit)
  );

  // The dividend register doubles as the quotient register: quotient bits enter at the LSB.
  assign dvd_shl = (dvd_q << 1) | WIDTH'(step_q_bit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvd_d = a;
          b_d   = b;
          p_d   = '0;
          cnt_d = CNT_W'(WIDTH);
          if (b == '0) begin
            q_d     = '1;
            r_d     = a;
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        p_d   = step_p;
        dvd_d = dvd_shl;
        cnt_d = cnt_q - CNT_W'(1);
        // Results are published only on the final step, never partially
        if (cnt_q == CNT_W'(1)) begin
          q_d     = dvd_shl;
          r_d     = step_p[WIDTH-1:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      dvd_q   <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=3 and WIDTH=8.
module tb_seq_divider;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv3, or3, ir3, ov3, dz3;
  logic [2:0] a3, b3, q3, r3;
  logic       iv8, or8, ir8, ov8, dz8;
  logic [7:0] a8, b8, q8, r8;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .out_valid(ov3), .out_ready(or3), .q(q3), .r(r3), .dbz(dz3)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .q(q8), .r(r8), .dbz(dz8)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic f_ir(int s);
    return (s == 0) ? ir3 : ir8;
  endfunction
  function automatic logic f_ov(int s);
    return (s == 0) ? ov3 : ov8;
  endfunction
  function automatic logic f_dz(int s);
    return (s == 0) ? dz3 : dz8;
  endfunction
  function automatic logic [7:0] f_q(int s);
    return (s == 0) ? {5'b0, q3} : q8;
  endfunction
  function automatic logic [7:0] f_r(int s);
    return (s == 0) ? {5'b0, r3} : r8;
  endfunction

  task automatic drv_in(int s, logic v, logic [7:0] av, logic [7:0] bv);
    if (s == 0) begin iv3 = v; a3 = av[2:0]; b3 = bv[2:0]; end
    else        begin iv8 = v; a8 = av;      b8 = bv;      end
  endtask

  task automatic drv_or(int s, logic v);
    if (s == 0) or3 = v; else or8 = v;
  endtask

  // One full transaction: optional idle cycles, accept, latency check,
  // optional consumer stall (with ignored junk requests), handshake and compare.
  task automatic send(int s, logic [7:0] av, logic [7:0] bv, int pre, int stall, bit junk);
    exp_t       e;
    int         w = (s == 0) ? 3 : 8;
    logic [7:0] m = (s == 0) ? 8'h07 : 8'hFF;
    int         n;
    int         prod;
    logic [7:0] hq, hr;
    logic       hd;
    e.a = av;
    e.b = bv;
    if (bv == 8'd0) begin e.q = m; e.r = av; e.dbz = 1'b1; end
    else begin e.q = av / bv; e.r = av % bv; e.dbz = 1'b0; end
    sb.push_back(e);
    vec_cnt++;
    repeat (pre) tick();
    drv_in(s, 1'b1, av, bv);
    n = 0;
    while (!f_ir(s) && n < 50) begin tick(); n++; end
    chk("accept_ready", 32'(f_ir(s)), 32'd1);
    tick();
    drv_in(s, 1'b0, 8'($urandom), 8'($urandom));
    n = 0;
    while (!f_ov(s) && n < 40) begin
      if (n == 0) chk("calc_in_ready", 32'(f_ir(s)), 32'd0);
      tick();
      n++;
    end
    chk("latency", n, (bv == 8'd0) ? 0 : w);
    hq = f_q(s); hr = f_r(s); hd = f_dz(s);
    for (int i = 0; i < stall; i++) begin
      if (junk) drv_in(s, 1'b1, 8'($urandom), 8'($urandom));
      tick();
      chk("hold_valid", 32'(f_ov(s)), 32'd1);
      chk("hold_in_ready", 32'(f_ir(s)), 32'd0);
      chk("hold_q", 32'(f_q(s)), 32'(hq));
      chk("hold_r", 32'(f_r(s)), 32'(hr));
      chk("hold_dbz", 32'(f_dz(s)), 32'(hd));
    end
    drv_in(s, 1'b0, 8'd0, 8'd0);
    drv_or(s, 1'b1);
    e = sb.pop_front();
    chk("q", 32'(f_q(s)), 32'(e.q));
    chk("r", 32'(f_r(s)), 32'(e.r));
    chk("dbz", 32'(f_dz(s)), 32'(e.dbz));
    if (e.b != 8'd0) begin
      prod = int'(f_q(s)) * int'(e.b) + int'(f_r(s));
      chk("qb_plus_r", prod, 32'(e.a));
      chk("r_lt_b", 32'(f_r(s) < e.b), 32'd1);
    end
    tick();
    drv_or(s, 1'b0);
    chk("post_out_valid", 32'(f_ov(s)), 32'd0);
    chk("post_in_ready", 32'(f_ir(s)), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drv_in(0, 1'b0, 8'd0, 8'd0);
    drv_in(1, 1'b0, 8'd0, 8'd0);
    drv_or(0, 1'b0);
    drv_or(1, 1'b0);
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready", 32'(f_ir(s)), 32'd1);
      chk("rst_out_valid", 32'(f_ov(s)), 32'd0);
      chk("rst_q", 32'(f_q(s)), 32'd0);
      chk("rst_r", 32'(f_r(s)), 32'd0);
      chk("rst_dbz", 32'(f_dz(s)), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    send(0, 8'd7, 8'd2, 0, 0, 1'b0);
    send(0, 8'd5, 8'd0, 0, 0, 1'b0);
    send(0, 8'd3, 8'd7, 1, 0, 1'b0);
    send(0, 8'd7, 8'd1, 0, 0, 1'b0);
    send(0, 8'd0, 8'd5, 0, 0, 1'b0);
    send(0, 8'd6, 8'd4, 0, 5, 1'b1);

    // Asynchronous reset in the middle of a 7/3 computation
    drv_in(0, 1'b1, 8'd7, 8'd3);
    tick();
    drv_in(0, 1'b0, 8'd0, 8'd0);
    tick();
    chk("midcalc_busy", 32'(f_ir(0)), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_ready", 32'(f_ir(0)), 32'd1);
    chk("async_out_valid", 32'(f_ov(0)), 32'd0);
    chk("async_q", 32'(f_q(0)), 32'd0);
    chk("async_r", 32'(f_r(0)), 32'd0);
    chk("async_dbz", 32'(f_dz(0)), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_no_valid", 32'(f_ov(0)), 32'd0);
    end
    send(0, 8'd6, 8'd3, 0, 0, 1'b0);

    for (int av = 0; av < 8; av++) begin
      for (int bv = 0; bv < 8; bv++) begin
        send(0, 8'(av), 8'(bv), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      end
    end

    send(1, 8'd255, 8'd1, 0, 0, 1'b0);
    send(1, 8'd255, 8'd255, 0, 0, 1'b0);
    send(1, 8'd200, 8'd0, 0, 2, 1'b1);
    send(1, 8'd0, 8'd13, 0, 0, 1'b0);
    send(1, 8'd254, 8'd255, 0, 0, 1'b0);
    send(1, 8'd128, 8'd3, 1, 1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      send(1, 8'($urandom), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
